// File: rtl/bus_cs_wait_ctrl_if.sv
// Bus-side signal bundle for bus_cs_wait_ctrl: processor strobes, latched address,
// chip selects, READY and the runtime decode-window configuration port.
interface bus_cs_wait_ctrl_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int WAIT_W     = 4
);
    // A single-channel build still needs a one-bit channel select.
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  ALE;
    logic                  IOM;
    logic                  RD_N;
    logic                  WR_N;
    logic [ADDR_WIDTH-1:0] BUS_ADDR;

    logic                  CFG_WE;
    logic [CH_W-1:0]       CFG_CH;
    logic [ADDR_WIDTH-1:0] CFG_BASE;
    logic [ADDR_WIDTH-1:0] CFG_MASK;
    logic                  CFG_IOM;
    logic [WAIT_W-1:0]     CFG_WAIT;
    logic                  CFG_EN;

    logic [ADDR_WIDTH-1:0] ADDRESS;
    logic [NUM_CH-1:0]     CS;
    logic                  READY;
    logic                  NO_HIT;
    logic                  MULTI_HIT;

    modport master (
        output ALE, IOM, RD_N, WR_N, BUS_ADDR,
        output CFG_WE, CFG_CH, CFG_BASE, CFG_MASK, CFG_IOM, CFG_WAIT, CFG_EN,
        input  ADDRESS, CS, READY, NO_HIT, MULTI_HIT
    );

    modport slave (
        input  ALE, IOM, RD_N, WR_N, BUS_ADDR,
        input  CFG_WE, CFG_CH, CFG_BASE, CFG_MASK, CFG_IOM, CFG_WAIT, CFG_EN,
        output ADDRESS, CS, READY, NO_HIT, MULTI_HIT
    );
endinterface

// File: rtl/bus_cs_wait_ctrl.sv
// 8088 bus address decoder and wait-state generator with NUM_CH programmable windows.
// Define BUS_CS_ERRCNT_EN to add the saturating 16-bit ERR_COUNT decode-error counter.
module bus_cs_wait_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 20,
    parameter int WAIT_W     = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    bus_cs_wait_ctrl_if.slave bus
`ifdef BUS_CS_ERRCNT_EN
    ,
    output logic [15:0]       ERR_COUNT
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DECODED,
        S_WAIT,
        S_DATA
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] cfg_base [NUM_CH];
    logic [ADDR_WIDTH-1:0] cfg_mask [NUM_CH];
    logic [WAIT_W-1:0]     cfg_wait [NUM_CH];
    logic [NUM_CH-1:0]     cfg_iom;
    logic [NUM_CH-1:0]     cfg_en;

    logic [ADDR_WIDTH-1:0] address_q;
    logic [NUM_CH-1:0]     cs_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic                  no_hit_q;
    logic                  multi_hit_q;

    logic [NUM_CH-1:0]     match;
    logic [NUM_CH-1:0]     sel_cs;
    logic [WAIT_W-1:0]     sel_wait;
    logic                  hit_none;
    logic                  hit_multi;
    logic                  strobes_idle;
    logic                  do_decode;
    logic                  cnt_dec;

    assign strobes_idle = bus.RD_N & bus.WR_N;

    // Window compare against the latched address; lowest matching index wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise the
        // paths that skip an assignment infer a latch.
        match    = '0;
        sel_cs   = '0;
        sel_wait = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match[i] = cfg_en[i] & (bus.IOM == cfg_iom[i]) &
                       ((address_q & cfg_mask[i]) == cfg_base[i]);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_cs    = '0;
                sel_cs[i] = 1'b1;
                sel_wait  = cfg_wait[i];
            end
        end
        hit_none  = (match == '0);
        hit_multi = ($countones(match) > 1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ALE overrides every state so a new bus cycle can never be missed.
    always_comb begin
        state_d   = state_q;
        do_decode = 1'b0;
        cnt_dec   = 1'b0;
        if (bus.ALE) begin
            state_d = S_ADDR;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ADDR: begin
                    do_decode = 1'b1;
                    state_d   = S_DECODED;
                end
                S_DECODED: begin
                    if (!strobes_idle) begin
                        state_d = ((wait_cnt_q != '0) && (cs_q != '0)) ? S_WAIT : S_DATA;
                    end
                end
                S_WAIT: begin
                    if (strobes_idle) begin
                        state_d = S_IDLE;
                    end else if (wait_cnt_q == WAIT_W'(1)) begin
                        state_d = S_DATA;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_DATA: begin
                    if (strobes_idle) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Address latch, chip selects, decode-error pulses and the wait counter.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!RESET_N) begin
            address_q   <= '0;
            cs_q        <= '0;
            wait_cnt_q  <= '0;
            no_hit_q    <= 1'b0;
            multi_hit_q <= 1'b0;
        end else begin
            no_hit_q    <= 1'b0;
            multi_hit_q <= 1'b0;
            if (bus.ALE) begin
                address_q <= bus.BUS_ADDR;
                cs_q      <= '0;
            end else if (do_decode) begin
                cs_q        <= sel_cs;
                wait_cnt_q  <= sel_wait;
                no_hit_q    <= hit_none;
                multi_hit_q <= hit_multi;
            end else if (cnt_dec) begin
                wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
            end
        end
    end

    // Configuration table; a write lands on the next edge, so an in-flight
    // decode keeps the wait count it already captured.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            // NOTE: the table is reset explicitly because enables must be known
            // before the first decode; it stays in flops, not a RAM macro.
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_base[i] <= '0;
                cfg_mask[i] <= '0;
                cfg_wait[i] <= '0;
            end
            cfg_iom <= '0;
            cfg_en  <= '0;
        end else if (bus.CFG_WE && (int'(bus.CFG_CH) < NUM_CH)) begin
            cfg_base[bus.CFG_CH] <= bus.CFG_BASE;
            cfg_mask[bus.CFG_CH] <= bus.CFG_MASK;
            cfg_wait[bus.CFG_CH] <= bus.CFG_WAIT;
            cfg_iom[bus.CFG_CH]  <= bus.CFG_IOM;
            cfg_en[bus.CFG_CH]   <= bus.CFG_EN;
        end
    end

`ifdef BUS_CS_ERRCNT_EN
    // Counts on the same edge the NO_HIT/MULTI_HIT pulse is registered.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ERR_COUNT <= '0;
        end else if (do_decode && (hit_none || hit_multi) && (ERR_COUNT != 16'hFFFF)) begin
            ERR_COUNT <= ERR_COUNT + 16'd1;
        end
    end
`endif

    assign bus.ADDRESS   = address_q;
    assign bus.CS        = cs_q;
    assign bus.READY     = (state_q != S_WAIT);
    assign bus.NO_HIT    = no_hit_q;
    assign bus.MULTI_HIT = multi_hit_q;

endmodule

// File: doc/bus_cs_wait_ctrl.md
# bus_cs_wait_ctrl

Parametrised address decoder and wait-state generator for the 8088 minimum/maximum-mode bus model. It replaces the fixed per-device chip-select equations and the tied-high READY with one clocked block. The block captures the demultiplexed address during ALE and decodes it against NUM_CH runtime-programmable base/mask/space windows. It drives one-hot chip selects to the MemoryOrIOModule instances and holds READY low for a per-channel number of wait states.

## Interface
Parameters:
- NUM_CH, 4, number of decode channels (1..16)
- ADDR_WIDTH, 20, width of latched bus address
- WAIT_W, 4, width of per-channel wait-state count (max 2^WAIT_W-1 waits)

Ports:
- CLK  in  1  bus clock; all state changes on rising edge
- RESET_N  in  1  synchronous, active-low reset
- ALE  in  1  address latch enable from processor
- IOM  in  1  1 = I/O cycle, 0 = memory cycle
- RD_N  in  1  read strobe, active low
- WR_N  in  1  write strobe, active low
- BUS_ADDR  in  ADDR_WIDTH  concatenated {A, AD} from processor
- CFG_WE  in  1  configuration write strobe
- CFG_CH  in  $clog2(NUM_CH)  channel being configured
- CFG_BASE  in  ADDR_WIDTH  channel base address
- CFG_MASK  in  ADDR_WIDTH  channel address mask
- CFG_IOM  in  1  channel address space (matches IOM)
- CFG_WAIT  in  WAIT_W  channel wait-state count
- CFG_EN  in  1  channel enable
- ADDRESS  out  ADDR_WIDTH  latched address
- CS  out  NUM_CH  one-hot chip selects
- READY  out  1  to processor READY
- NO_HIT  out  1  one-cycle pulse: decode matched no channel
- MULTI_HIT  out  1  one-cycle pulse: decode matched >1 channel

## Operation
- Channel i matches when EN[i] & (IOM == IOM_CFG[i]) & ((ADDRESS & MASK[i]) == BASE[i]).
- Multiple matches: lowest index wins; CS stays one-hot; MULTI_HIT pulses.
- No match: CS stays all-zero; NO_HIT pulses; READY stays 1, so the cycle never hangs.
- Config writes take effect on the next edge. A decode captures its channel's WAIT value at decode time, so a write during an active cycle affects only later cycles.
- FSM states:
  - IDLE: waits for ALE=1, then goes to ADDR.
  - ADDR: ADDRESS <= BUS_ADDR every cycle ALE=1. On the first cycle ALE=0, registers decode to CS and loads the wait counter, then goes to DECODED.
  - DECODED: on the first cycle (RD_N & WR_N)==0, goes to WAIT if count>0 and CS!=0, else to DATA.
  - WAIT: READY=0. Counter decrements each cycle; on reaching 0, goes to DATA.
  - DATA: READY=1. When RD_N & WR_N both 1, goes to IDLE; ALE=1 goes directly to ADDR.
- In any state, ALE=1 clears CS at the next edge and enters ADDR.
- RESET_N=0 mid-cycle: next edge forces IDLE. Config RAM: all EN=0, BASE/MASK/WAIT=0.
- Strobes deasserting during WAIT abort the wait: READY=1 next edge, then IDLE.

## Timing
- Reset values: ADDRESS=0, CS=0, READY=1, NO_HIT=0, MULTI_HIT=0.
- ADDRESS follows BUS_ADDR with 1-cycle latency while ALE=1 and holds afterwards.
- CS valid 1 cycle after the first edge with ALE sampled 0. NO_HIT/MULTI_HIT pulse on that same edge.
- READY falls 1 cycle after the strobe is first sampled low. It stays low exactly WAIT cycles, then rises.
- WAIT=0: READY never falls.

## Configuration
- BUS_CS_ERRCNT_EN defined: adds output ERR_COUNT (16 bits).
  - Saturating count of NO_HIT plus MULTI_HIT pulses; reset to 0.
  - A simultaneous NO_HIT and MULTI_HIT cannot occur.
- Undefined: no ERR_COUNT port and no counter logic.

## Test plan
- Reset with ALE/strobes active -> CS=0, READY=1, ADDRESS=0; after release, all channels disabled, so memory read at 0x12345 gives NO_HIT pulse.
- Decode and select: ch0 base 0x00000 mask 0x80000 mem, ch1 base 0x80000 mask 0x80000 mem; memory read 0x8ABCD -> CS=4'b0010 one cycle after ALE falls, READY stays 1.
- Wait states: ch2 base 0x1C00 mask 0xFE00 IOM=1, WAIT=3; I/O read 0x1D10 -> READY low exactly 3 cycles starting 1 cycle after RD_N low; CS=4'b0100.
- Overlap: ch0 and ch3 both match 0xFF05 I/O -> CS=4'b0001, MULTI_HIT one-cycle pulse; with macro, ERR_COUNT=1.
- Abort and reset mid-wait: WAIT=15, RD_N high after 2 wait cycles -> READY=1 next edge. Repeat with RESET_N low at wait cycle 5 -> READY=1, CS=0 next edge.
- Reconfigure during a WAIT=2 cycle to WAIT=5 -> current cycle inserts 2 waits, next cycle inserts 5.
